es_muldiv_unit: RTL

Parametrised multi-cycle multiply/divide engine with architectural HI/LO registers, attached beside the ALU in the execute stage. The exe stage issues MULT/MULTU/DIV/DIVU through a valid/ready handshake and holds its ready_go low until the unit signals done. Writes to HI/LO are cancelled when an exception flush arrives from a later stage. This extends the single-cycle execute datapath with configurable width and latency, abort-on-exception, and MTHI/MTLO/MFHI/MFLO support.

---
 rtl/es_muldiv_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/es_muldiv_unit.sv
// Multi-cycle multiply/divide engine with architectural HI/LO registers.
// Multiplies complete after MUL_LAT cycles; divides use a radix-2 restoring loop.
module es_muldiv_unit #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] hilo_wdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CNT_W = $clog2(DATA_W + MUL_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W);

    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    logic              sgn_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] rem, quo, dvs;

    logic                req_sgn;
    logic [DATA_W-1:0]   abs_src1, abs_src2;
    logic                mul_sgn;
    logic [DATA_W-1:0]   mul_a, mul_b;
    logic [2*DATA_W-1:0] mul_a_ext, mul_b_ext, product;
    logic [DATA_W:0]     shifted;
    logic                div_ge, div0, neg_q, neg_r;
    logic [DATA_W-1:0]   rem_nx, quo_nx, q_fix, r_fix;

    assign req_ready = (state == S_IDLE) && !flush;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) && !flush;

    // Operands are taken straight from the request while idle so MUL_LAT==1 can finish in one cycle.
    always_comb begin
        req_sgn  = ~req_op[0];
        abs_src1 = (req_sgn && req_src1[DATA_W-1]) ? -req_src1 : req_src1;
        abs_src2 = (req_sgn && req_src2[DATA_W-1]) ? -req_src2 : req_src2;
        if (state == S_IDLE) begin
            mul_sgn = req_sgn;
            mul_a   = req_src1;
            mul_b   = req_src2;
        end else begin
            mul_sgn = sgn_q;
            mul_a   = a_q;
            mul_b   = b_q;
        end
        mul_a_ext = {{DATA_W{mul_sgn & mul_a[DATA_W-1]}}, mul_a};
        mul_b_ext = {{DATA_W{mul_sgn & mul_b[DATA_W-1]}}, mul_b};
        product   = mul_a_ext * mul_b_ext;
    end

    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        div_ge  = shifted >= {1'b0, dvs};
        rem_nx  = div_ge ? (shifted[DATA_W-1:0] - dvs) : shifted[DATA_W-1:0];
        quo_nx  = {quo[DATA_W-2:0], div_ge};
        div0    = (b_q == '0);
        neg_q   = sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        neg_r   = sgn_q & a_q[DATA_W-1];
        q_fix   = div0 ? '1  : (neg_q ? -quo_nx : quo_nx);
        r_fix   = div0 ? a_q : (neg_r ? -rem_nx : rem_nx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= '0;
            sgn_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= hilo_wdata;
                    if (lo_we) lo <= hilo_wdata;
                    if (req_valid && req_ready) begin
                        sgn_q <= req_sgn;
                        a_q   <= req_src1;
                        b_q   <= req_src2;
                        count <= CNT_W'(1);
                        if (!req_op[1]) begin
                            if (MUL_LAT == 1) begin
                                state  <= S_DONE;
                                res_hi <= product[2*DATA_W-1:DATA_W];
                                res_lo <= product[DATA_W-1:0];
                            end else begin
                                state <= S_MUL;
                            end
                        end else begin
                            state <= S_DIV;
                            rem   <= '0;
                            quo   <= abs_src1;
                            dvs   <= abs_src2;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (count == MUL_LAST) begin
                        state  <= S_DONE;
                        res_hi <= product[2*DATA_W-1:DATA_W];
                        res_lo <= product[DATA_W-1:0];
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        rem   <= rem_nx;
                        quo   <= quo_nx;
                        count <= count + 1'b1;
                        // Final iteration and sign fix-up share the edge entering DONE.
                        if (count == DIV_LAST) begin
                            state  <= S_DONE;
                            res_hi <= r_fix;
                            res_lo <= q_fix;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
            endcase
        end
    end

endmodule
